// File: rtl/bsg_lru_pseudo_tree_tracker.sv
// Multi-set pseudo-LRU tree tracker. One (ways_p-1)-bit binary tree per set is
// kept in flops. Hits touch the tree. Victim requests return a registered way
// through a valid/ready/yumi handshake and allocate that way at the accept edge.
// Optional feature macro: BSG_LRU_PSEUDO_TREE_TRACKER_INVALIDATE_EN adds a per-set
// tree clear (inv_v_i / inv_set_i).
module bsg_lru_pseudo_tree_tracker #(
  parameter  int unsigned ways_p  = 8,
  parameter  int unsigned sets_p  = 4,
  localparam int unsigned lg_ways = $clog2(ways_p),
  localparam int unsigned lg_sets = (sets_p > 1) ? $clog2(sets_p) : 1,
  localparam int unsigned nodes   = ways_p - 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               touch_v_i,
  input  logic [lg_sets-1:0] touch_set_i,
  input  logic [lg_ways-1:0] touch_way_i,
`ifdef BSG_LRU_PSEUDO_TREE_TRACKER_INVALIDATE_EN
  input  logic               inv_v_i,
  input  logic [lg_sets-1:0] inv_set_i,
`endif
  input  logic               vic_v_i,
  output logic               vic_ready_o,
  input  logic [lg_sets-1:0] vic_set_i,
  output logic               vic_v_o,
  output logic [lg_ways-1:0] vic_way_o,
  input  logic               vic_yumi_i
);

  // Follow the node pointers from the root; node i has children 2i+1 / 2i+2.
  function automatic logic [lg_ways-1:0] tree_encode(input logic [nodes-1:0] t);
    logic [lg_ways-1:0] w;
    int                 idx;
    logic               b;
    w   = '0;
    idx = 0;
    for (int k = 0; k < int'(lg_ways); k++) begin
      b = 1'b0;
      for (int n = 0; n < int'(nodes); n++) begin
        if (n == idx) b = t[n];
      end
      w[int'(lg_ways)-1-k] = b;
      idx = b ? (2*idx + 2) : (2*idx + 1);
    end
    return w;
  endfunction

  // Point every node on way w's path away from w.
  function automatic logic [nodes-1:0] tree_touch(input logic [nodes-1:0] t,
                                                  input logic [lg_ways-1:0] w);
    logic [nodes-1:0] r;
    int               idx;
    logic             b;
    r   = t;
    idx = 0;
    for (int k = 0; k < int'(lg_ways); k++) begin
      b = w[int'(lg_ways)-1-k];
      for (int n = 0; n < int'(nodes); n++) begin
        if (n == idx) r[n] = ~b;
      end
      idx = b ? (2*idx + 2) : (2*idx + 1);
    end
    return r;
  endfunction

  logic [nodes-1:0]   tree_r [sets_p];
  logic [nodes-1:0]   tree_n [sets_p];
  logic [lg_ways-1:0] vic_way_c;
  logic               vic_v_r;
  logic [lg_ways-1:0] vic_way_r;
  logic               vic_accept_c;

  // Single-entry response register; a consume frees the slot in the same cycle.
  assign vic_ready_o  = ~vic_v_r | vic_yumi_i;
  assign vic_accept_c = vic_v_i & vic_ready_o;
  assign vic_v_o      = vic_v_r;
  assign vic_way_o    = vic_way_r;

  // Per-set next tree: invalidate, then touch, then victim select and allocate.
  // Out-of-range set indices match no set, so they update nothing and yield way 0.
  always_comb begin
    vic_way_c = '0;
    for (int s = 0; s < int'(sets_p); s++) begin
      tree_n[s] = tree_r[s];
`ifdef BSG_LRU_PSEUDO_TREE_TRACKER_INVALIDATE_EN
      if (inv_v_i && (inv_set_i == lg_sets'(s))) tree_n[s] = '0;
`endif
      if (touch_v_i && (touch_set_i == lg_sets'(s)))
        tree_n[s] = tree_touch(tree_n[s], touch_way_i);
      if (vic_set_i == lg_sets'(s)) begin
        vic_way_c = tree_encode(tree_n[s]);
        if (vic_accept_c) tree_n[s] = tree_touch(tree_n[s], vic_way_c);
      end
    end
  end

  // Tree state storage.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int s = 0; s < int'(sets_p); s++) tree_r[s] <= '0;
    end else begin
      for (int s = 0; s < int'(sets_p); s++) tree_r[s] <= tree_n[s];
    end
  end

  // Victim response register: load on accept, clear on consume without reload.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vic_v_r   <= 1'b0;
      vic_way_r <= '0;
    end else if (vic_accept_c) begin
      vic_v_r   <= 1'b1;
      vic_way_r <= vic_way_c;
    end else if (vic_yumi_i) begin
      vic_v_r   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bsg_lru_pseudo_tree_tracker.sv
// Directed self-checking bench for bsg_lru_pseudo_tree_tracker (ways_p=8, sets_p=4).
module tb_bsg_lru_pseudo_tree_tracker;

  logic       clk;
  logic       rst_n;
  logic       touch_v;
  logic [1:0] touch_set;
  logic [2:0] touch_way;
  logic       vic_v;
  logic       vic_ready;
  logic [1:0] vic_set;
  logic       vic_vo;
  logic [2:0] vic_way;
  logic       yumi;
`ifdef BSG_LRU_PSEUDO_TREE_TRACKER_INVALIDATE_EN
  logic       inv_v;
  logic [1:0] inv_set;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bsg_lru_pseudo_tree_tracker #(.ways_p(8), .sets_p(4)) dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .touch_v_i   (touch_v),
    .touch_set_i (touch_set),
    .touch_way_i (touch_way),
`ifdef BSG_LRU_PSEUDO_TREE_TRACKER_INVALIDATE_EN
    .inv_v_i     (inv_v),
    .inv_set_i   (inv_set),
`endif
    .vic_v_i     (vic_v),
    .vic_ready_o (vic_ready),
    .vic_set_i   (vic_set),
    .vic_v_o     (vic_vo),
    .vic_way_o   (vic_way),
    .vic_yumi_i  (yumi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    touch_v = 1'b0; touch_set = '0; touch_way = '0;
    vic_v = 1'b0; vic_set = '0; yumi = 1'b0;
`ifdef BSG_LRU_PSEUDO_TREE_TRACKER_INVALIDATE_EN
    inv_v = 1'b0; inv_set = '0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (vic_vo !== 1'b0) begin n_fail++; $display("FAIL reset_v got %b want 0", vic_vo); end
    n_checks++; if (vic_way !== 3'd0) begin n_fail++; $display("FAIL reset_way got %0d want 0", vic_way); end
    n_checks++; if (vic_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", vic_ready); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_seq [8];
    exp_seq = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    do_reset();
    yumi = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_checks++;
        if (vic_vo !== 1'b1 || vic_way !== exp_seq[k-1]) begin
          n_fail++;
          $display("FAIL b2b_%0d got v=%b way=%0d want v=1 way=%0d", k-1, vic_vo, vic_way, exp_seq[k-1]);
        end
      end
      vic_v   = (k < 8);
      vic_set = 2'd2;
    end
    @(negedge clk);
    n_checks++; if (vic_vo !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got v=%b want 0", vic_vo); end
    yumi = 1'b0;
  endtask

  task automatic test_sets();
    do_reset();
    @(negedge clk);
    touch_v = 1'b1; touch_set = 2'd1; touch_way = 3'd3;
    @(negedge clk);
    touch_v = 1'b0; vic_v = 1'b1; vic_set = 2'd1;
    @(negedge clk);
    n_checks++;
    if (vic_vo !== 1'b1 || vic_way !== 3'd4) begin
      n_fail++; $display("FAIL sets_s1 got v=%b way=%0d want v=1 way=4", vic_vo, vic_way);
    end
    vic_v = 1'b1; vic_set = 2'd0; yumi = 1'b1;
    @(negedge clk);
    n_checks++;
    if (vic_vo !== 1'b1 || vic_way !== 3'd0) begin
      n_fail++; $display("FAIL sets_s0 got v=%b way=%0d want v=1 way=0", vic_vo, vic_way);
    end
    vic_v = 1'b0;
    @(negedge clk);
    yumi = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    vic_v = 1'b1; vic_set = 2'd0; yumi = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (vic_vo !== 1'b1 || vic_way !== 3'd0 || vic_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_%0d got v=%b way=%0d rdy=%b want v=1 way=0 rdy=0", k, vic_vo, vic_way, vic_ready);
      end
    end
    vic_v = 1'b0; yumi = 1'b1;
    #1;
    n_checks++; if (vic_ready !== 1'b1) begin n_fail++; $display("FAIL stall_yumi_ready got %b want 1", vic_ready); end
    @(negedge clk);
    n_checks++; if (vic_vo !== 1'b0) begin n_fail++; $display("FAIL stall_clear got v=%b want 0", vic_vo); end
    yumi = 1'b0; vic_v = 1'b1; vic_set = 2'd0;
    @(negedge clk);
    n_checks++;
    if (vic_vo !== 1'b1 || vic_way !== 3'd4) begin
      n_fail++; $display("FAIL stall_next got v=%b way=%0d want v=1 way=4", vic_vo, vic_way);
    end
    vic_v = 1'b0; yumi = 1'b1;
    @(negedge clk);
    yumi = 1'b0;
  endtask

  task automatic test_same_cycle();
    do_reset();
    @(negedge clk);
    touch_v = 1'b1; touch_set = 2'd3; touch_way = 3'd0;
    vic_v = 1'b1; vic_set = 2'd3;
    @(negedge clk);
    touch_v = 1'b0;
    n_checks++;
    if (vic_vo !== 1'b1 || vic_way !== 3'd4) begin
      n_fail++; $display("FAIL same_cycle got v=%b way=%0d want v=1 way=4", vic_vo, vic_way);
    end
    yumi = 1'b1; vic_v = 1'b1; vic_set = 2'd3;
    @(negedge clk);
    n_checks++;
    if (vic_vo !== 1'b1 || vic_way !== 3'd2) begin
      n_fail++; $display("FAIL same_cycle_next got v=%b way=%0d want v=1 way=2", vic_vo, vic_way);
    end
    vic_v = 1'b0;
    @(negedge clk);
    yumi = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    vic_v = 1'b1; vic_set = 2'd1; yumi = 1'b1;
    repeat (3) @(negedge clk);
    vic_v = 1'b0; yumi = 1'b0;
    n_checks++;
    if (vic_vo !== 1'b1 || vic_way !== 3'd2) begin
      n_fail++; $display("FAIL mid_pending got v=%b way=%0d want v=1 way=2", vic_vo, vic_way);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (vic_vo !== 1'b0) begin n_fail++; $display("FAIL mid_async_drop got v=%b want 0", vic_vo); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vic_v = 1'b1; vic_set = 2'd1; yumi = 1'b1;
    @(negedge clk);
    vic_set = 2'd2;
    n_checks++;
    if (vic_vo !== 1'b1 || vic_way !== 3'd0) begin
      n_fail++; $display("FAIL mid_after_s1 got v=%b way=%0d want v=1 way=0", vic_vo, vic_way);
    end
    @(negedge clk);
    vic_v = 1'b0;
    n_checks++;
    if (vic_vo !== 1'b1 || vic_way !== 3'd0) begin
      n_fail++; $display("FAIL mid_after_s2 got v=%b way=%0d want v=1 way=0", vic_vo, vic_way);
    end
    @(negedge clk);
    yumi = 1'b0;
  endtask

`ifdef BSG_LRU_PSEUDO_TREE_TRACKER_INVALIDATE_EN
  task automatic test_invalidate();
    logic [2:0] exp_seq [3];
    exp_seq = '{3'd0, 3'd4, 3'd2};
    do_reset();
    yumi = 1'b1;
    @(negedge clk);
    vic_v = 1'b1; vic_set = 2'd1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_checks++;
        if (vic_way !== exp_seq[k-1]) begin
          n_fail++; $display("FAIL inv_alloc_%0d got %0d want %0d", k-1, vic_way, exp_seq[k-1]);
        end
      end
      vic_v = (k < 3); vic_set = 2'd0;
    end
    inv_v = 1'b1; inv_set = 2'd0;
    @(negedge clk);
    inv_v = 1'b0; vic_v = 1'b1; vic_set = 2'd0;
    @(negedge clk);
    vic_set = 2'd1;
    n_checks++;
    if (vic_vo !== 1'b1 || vic_way !== 3'd0) begin
      n_fail++; $display("FAIL inv_s0 got v=%b way=%0d want v=1 way=0", vic_vo, vic_way);
    end
    @(negedge clk);
    vic_v = 1'b0;
    n_checks++;
    if (vic_vo !== 1'b1 || vic_way !== 3'd4) begin
      n_fail++; $display("FAIL inv_s1 got v=%b way=%0d want v=1 way=4", vic_vo, vic_way);
    end
    @(negedge clk);
    yumi = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_sets();
    test_stall();
    test_same_cycle();
    test_reset_mid();
`ifdef BSG_LRU_PSEUDO_TREE_TRACKER_INVALIDATE_EN
    test_invalidate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_lru_pseudo_tree_tracker.md
Name: bsg_lru_pseudo_tree_tracker

Overview:
- Stateful, multi-set pseudo-LRU tracker for set-associative caches.
- Holds one (ways_p-1)-bit binary tree per set in flops.
- Updates the tree on hits (touch).
- Returns a registered victim way on request, through a valid/ready/yumi handshake, and auto-allocates that victim.
- Sits beside the tag array in the cache miss path. Replaces the combinational-only tree encoder plus ad-hoc state registers.

Parameters:
- ways_p, 8: associativity; power of 2, >= 2; lg_ways = $clog2(ways_p).
- sets_p, 4: number of tracked sets, >= 1; set index width lg_sets = max(1, $clog2(sets_p)).

Ports:
- clk_i, input, 1: clock.
- reset_n_i, input, 1: asynchronous, active-low reset.
- touch_v_i, input, 1: hit update; always accepted.
- touch_set_i, input, lg_sets: set of hit.
- touch_way_i, input, lg_ways: way hit.
- vic_v_i, input, 1: victim request valid.
- vic_ready_o, output, 1: request accepted when vic_v_i & vic_ready_o.
- vic_set_i, input, lg_sets: set for victim request.
- vic_v_o, output, 1: victim response valid.
- vic_way_o, output, lg_ways: victim way.
- vic_yumi_i, input, 1: consumer takes response; legal only when vic_v_o = 1.

Behaviour:
- Tree layout per set:
  - Node 0 is the root. Level k uses nodes 2^k-1 .. 2^(k+1)-2.
  - At level k, the node index is 2^k-1 + (way bits above level k, MSB first).
- Encode: way bit at level k (MSB = level 0) = value of the node on the path.
- Touch of way w: every node on w's path is set to ~(w bit at that level). The node then points away from w.
- Reset (async, reset_n_i low): all tree bits 0; vic_v_o = 0; vic_way_o = 0. The first victim of every set is way 0.
- vic_ready_o = ~vic_v_o | vic_yumi_i (combinational; single-entry output register with pass-through on consume).
- Latency:
  - A request accepted in cycle N gives vic_v_o = 1 and vic_way_o valid at the N+1 edge.
  - The response is held stable until the yumi cycle.
  - If yumi and a new accept happen in the same cycle, vic_v_o stays 1 with the new way.
  - Yumi without a new accept clears vic_v_o.
- Auto-allocate: an accepted request also touches the returned victim in that set, at the accept edge.
- Same-cycle ordering per set (next-state computation):
  - (1) touch update applied;
  - (2) victim computed from the post-touch tree;
  - (3) victim path update applied, overriding overlapping nodes.
- Different sets in the same cycle update independently.
- Set index >= sets_p:
  - touch is ignored;
  - a victim request is accepted, returns way 0, and updates nothing.
- Reset asserted mid-handshake: the response is dropped (vic_v_o = 0 asynchronously) and all trees are cleared.
- No combinational path from inputs to vic_way_o / vic_v_o; only vic_ready_o depends on vic_yumi_i.

Optional Feature:
- Macro: BSG_LRU_PSEUDO_TREE_TRACKER_INVALIDATE_EN.
- Defined:
  - Adds ports inv_v_i (input, 1) and inv_set_i (input, lg_sets).
  - When inv_v_i = 1, the tree of inv_set_i is cleared to all-zero.
  - Invalidate is applied before the touch and victim steps of the same cycle. A same-cycle victim request on that set therefore sees a tree whose only update is the same-cycle touch, if any.
  - With no touch that cycle, the request returns way 0.
- Undefined: the ports are absent and no clear path exists.

Test Plan:
- ways_p=8, sets_p=4:
  - Reset, then 8 back-to-back requests on set 2 with vic_yumi_i tied 1 -> vic_way_o sequence 0, 4, 2, 6, 1, 5, 3, 7, one per cycle, first valid one cycle after the first accept.
  - Reset, touch set 1 way 3, then request set 1 -> way 4; request set 0 -> way 0 (sets independent).
  - Request set 0 with vic_yumi_i held 0 for 5 cycles -> vic_v_o = 1, vic_way_o = 0 stable, vic_ready_o = 0, a second vic_v_i is not accepted. Yumi then gives vic_ready_o = 1 in that cycle.
  - Same cycle: touch set 3 way 0 plus request set 3 after reset -> response way 4. Next request on set 3 -> way 2.
  - Assert reset_n_i low while vic_v_o = 1 -> vic_v_o drops to 0 without a clock edge; next request on any set -> way 0.
  - With BSG_LRU_PSEUDO_TREE_TRACKER_INVALIDATE_EN: allocate set 0 three times (0, 4, 2), assert inv_v_i on set 0, then request -> way 0 and set 1 unaffected.
